board_step_ctrl: RTL and testbench

BOARD_STEP_CTRL -- requirements
Module: board_step_ctrl

---
 rtl/board_step_ctrl.sv | 165 ++++++++++++++++
 tb/tb_board_step_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_step_ctrl.sv
// rtl/board_step_ctrl.sv - 8x8 life-board generation stepper with row-write port
module board_step_ctrl #(
  parameter int WRAP  = 0,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [63:0]      cells,
  input  logic             step,
  input  logic             user_req,
  input  logic [2:0]       user_row,
  input  logic [7:0]       user_val,
  output logic             user_ack,
  output logic             load_r,
  output logic [2:0]       r_select,
  output logic [7:0]       r_val,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_count
);

  localparam bit WRAP_EN = (WRAP != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_n;
  logic       step_pend;
  logic [2:0] row;
  logic [63:0] snap;
  logic       accept;

  logic [2:0] row_up;
  logic [2:0] row_dn;
  logic [7:0] up_row;
  logic [7:0] mid_row;
  logic [7:0] dn_row;
  logic [7:0] next_row;

  // Bit c of the result holds the neighbour in column c-1 (west).
  function automatic logic [7:0] west_of(input logic [7:0] x);
    west_of = WRAP_EN ? {x[6:0], x[7]} : {x[6:0], 1'b0};
  endfunction

  // Bit c of the result holds the neighbour in column c+1 (east).
  function automatic logic [7:0] east_of(input logic [7:0] x);
    east_of = WRAP_EN ? {x[0], x[7:1]} : {1'b0, x[7:1]};
  endfunction

  // 3-bit arithmetic gives the toroidal row index for free.
  assign row_up = row - 3'd1;
  assign row_dn = row + 3'd1;

  // Fetch the current row and its vertical neighbours from the frozen snapshot.
  always_comb begin
    mid_row = snap[{row, 3'b000} +: 8];
    up_row  = (WRAP_EN || (row != 3'd0)) ? snap[{row_up, 3'b000} +: 8] : 8'h00;
    dn_row  = (WRAP_EN || (row != 3'd7)) ? snap[{row_dn, 3'b000} +: 8] : 8'h00;
  end

  // Count the eight neighbours of every cell in the row and apply the life rule.
  always_comb begin
    logic [7:0] uw;
    logic [7:0] ue;
    logic [7:0] mw;
    logic [7:0] me;
    logic [7:0] dw;
    logic [7:0] de;
    logic [3:0] n;
    uw       = west_of(up_row);
    ue       = east_of(up_row);
    mw       = west_of(mid_row);
    me       = east_of(mid_row);
    dw       = west_of(dn_row);
    de       = east_of(dn_row);
    n        = 4'd0;
    next_row = 8'h00;
    for (int c = 0; c < 8; c++) begin
      n = 4'(uw[c]) + 4'(up_row[c]) + 4'(ue[c]) +
          4'(mw[c]) + 4'(me[c]) +
          4'(dw[c]) + 4'(dn_row[c]) + 4'(de[c]);
      next_row[c] = (n == 4'd3) || (mid_row[c] && (n == 4'd2));
    end
  end

  // Next-state and output decode; user writes only ever land while idle.
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    load_r   = 1'b0;
    r_select = 3'd0;
    r_val    = 8'h00;
    user_ack = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (user_req) begin
          load_r   = 1'b1;
          r_select = user_row;
          r_val    = user_val;
          user_ack = 1'b1;
        end else if (step_pend || step) begin
          accept  = 1'b1;
          state_n = WRITE;
        end
      end
      WRITE: begin
        busy     = 1'b1;
        load_r   = 1'b1;
        r_select = row;
        r_val    = next_row;
        if (row == 3'd7) begin
          state_n = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Pending-step flag, snapshot capture, row walker and generation counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      step_pend <= 1'b0;
      row       <= 3'd0;
      snap      <= 64'd0;
      gen_count <= '0;
    end else begin
      if (accept) begin
        snap      <= cells;
        row       <= 3'd0;
        step_pend <= 1'b0;
      end else if (step) begin
        step_pend <= 1'b1;
      end
      if (state == WRITE) begin
        row <= row + 3'd1;
      end
      if (state == DONE) begin
        gen_count <= gen_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_board_step_ctrl.sv
// tb/tb_board_step_ctrl.sv - scoreboard bench for board_step_ctrl (flat and toroidal instances)
module tb_board_step_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       step;
  logic       user_req;
  logic [2:0] user_row;
  logic [7:0] user_val;

  logic [63:0] board0 = '0;
  logic [63:0] board1 = '0;

  logic        lr0, ua0, bz0, dn0;
  logic [2:0]  rs0;
  logic [7:0]  rv0;
  logic [15:0] gc0;
  logic        lr1, ua1, bz1, dn1;
  logic [2:0]  rs1;
  logic [7:0]  rv1;
  logic [1:0]  gc1;

  board_step_ctrl #(.WRAP(0), .GEN_W(16)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .cells(board0), .step(step),
    .user_req(user_req), .user_row(user_row), .user_val(user_val),
    .user_ack(ua0), .load_r(lr0), .r_select(rs0), .r_val(rv0),
    .busy(bz0), .done(dn0), .gen_count(gc0)
  );

  board_step_ctrl #(.WRAP(1), .GEN_W(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .cells(board1), .step(step),
    .user_req(user_req), .user_row(user_row), .user_val(user_val),
    .user_ack(ua1), .load_r(lr1), .r_select(rs1), .r_val(rv1),
    .busy(bz1), .done(dn1), .gen_count(gc1)
  );

  // External board memories written through the row-write port
  always @(posedge clk) begin
    if (lr0) board0[{rs0, 3'b000} +: 8] <= rv0;
    if (lr1) board1[{rs1, 3'b000} +: 8] <= rv1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference life rule on an 8x8 grid, plain 2-D neighbour counting
  function automatic logic [63:0] life(input logic [63:0] b, input bit wrap);
    logic [63:0] o;
    int n, rr, cc;
    o = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
            end
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
              n += int'(b[rr*8+cc]);
          end
        end
        o[r*8+c] = (n == 3) || (b[r*8+c] && n == 2);
      end
    end
    return o;
  endfunction

  typedef struct packed {
    logic [2:0] row;
    logic [7:0] val;
  } uw_t;

  uw_t uq0[$];
  uw_t uq1[$];
  int  gq0[$];
  int  gq1[$];

  bit          mon_en = 1'b0;
  bit          in_gen[2];
  int          phase[2];
  logic [63:0] exp_b[2];
  int          exp_cnt[2];
  bit          after_done[2];

  task automatic check_dut(input int d, input logic lr, input logic ua, input logic bz,
                           input logic dn, input logic [2:0] rs, input logic [7:0] rv,
                           input int gc, input logic [63:0] brd);
    string p;
    int    modv;
    bit    ad;
    bit    empty;
    uw_t   u;
    int    tok;
    p    = (d == 0) ? "d0" : "d1";
    modv = (d == 0) ? 65536 : 4;
    chk({p, "_gen_count"}, gc, exp_cnt[d]);
    ad = after_done[d];
    after_done[d] = 1'b0;
    if (!in_gen[d] && bz) begin
      chk({p, "_idle_gap"}, ad, 0);
      empty = (d == 0) ? (gq0.size() == 0) : (gq1.size() == 0);
      if (empty) chk({p, "_unexpected_gen"}, 1, 0);
      else if (d == 0) tok = gq0.pop_front();
      else tok = gq1.pop_front();
      exp_b[d]  = life(brd, d == 1);
      in_gen[d] = 1'b1;
      phase[d]  = 0;
    end
    if (in_gen[d]) begin
      chk({p, "_busy"}, bz, 1);
      chk({p, "_ack_busy"}, ua, 0);
      if (phase[d] < 8) begin
        chk({p, "_load_r"}, lr, 1);
        chk({p, "_r_select"}, rs, phase[d]);
        chk({p, "_r_val"}, rv, exp_b[d][8*phase[d] +: 8]);
        chk({p, "_done_early"}, dn, 0);
      end else begin
        chk({p, "_done"}, dn, 1);
        chk({p, "_load_done"}, lr, 0);
        exp_cnt[d]    = (exp_cnt[d] + 1) % modv;
        in_gen[d]     = 1'b0;
        after_done[d] = 1'b1;
      end
      phase[d]++;
    end else begin
      chk({p, "_busy_idle"}, bz, 0);
      chk({p, "_done_idle"}, dn, 0);
      chk({p, "_ack_idle"}, ua, user_req);
      if (ua) begin
        empty = (d == 0) ? (uq0.size() == 0) : (uq1.size() == 0);
        if (empty) begin
          chk({p, "_unexpected_ack"}, 1, 0);
        end else begin
          u = (d == 0) ? uq0.pop_front() : uq1.pop_front();
          chk({p, "_user_load"}, lr, 1);
          chk({p, "_user_row"}, rs, u.row);
          chk({p, "_user_val"}, rv, u.val);
        end
      end else begin
        chk({p, "_idle_outs"}, {lr, rs, rv}, 0);
      end
    end
  endtask

  // Monitor: compare both instances every cycle, then account for reset and step requests
  always @(negedge clk) begin
    if (mon_en) begin
      check_dut(0, lr0, ua0, bz0, dn0, rs0, rv0, int'(gc0), board0);
      check_dut(1, lr1, ua1, bz1, dn1, rs1, rv1, int'(gc1), board1);
      if (!reset_n) begin
        for (int d = 0; d < 2; d++) begin
          in_gen[d]     = 1'b0;
          after_done[d] = 1'b0;
          exp_cnt[d]    = 0;
          phase[d]      = 0;
        end
        gq0.delete();
        gq1.delete();
      end else if (step) begin
        if (gq0.size() == 0) gq0.push_back(1);
        if (gq1.size() == 0) gq1.push_back(1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic user_write(input logic [2:0] row, input logic [7:0] val, input bit with_step);
    bit got;
    got      = 1'b0;
    user_row = row;
    user_val = val;
    user_req = 1'b1;
    step     = with_step;
    uq0.push_back({row, val});
    uq1.push_back({row, val});
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = ua0;
      @(posedge clk);
      #1;
      step = 1'b0;
    end
    user_req = 1'b0;
    if (!got) chk("user_ack_timeout", 0, 1);
  endtask

  task automatic load_board(input logic [63:0] b);
    for (int r = 0; r < 8; r++) user_write(3'(r), b[8*r +: 8], 1'b0);
  endtask

  task automatic wait_quiet();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (!bz0 && !bz1 && gq0.size() == 0 && gq1.size() == 0 && !in_gen[0] && !in_gen[1])
        ok = 1'b1;
    end
    if (!ok) chk("quiet_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset_n  = 1'b0;
    step     = 1'b0;
    user_req = 1'b0;
    user_row = 3'd0;
    user_val = 8'h00;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;

    chk("reset_busy", {bz0, bz1}, 0);
    chk("reset_done", {dn0, dn1}, 0);
    chk("reset_load", {lr0, lr1}, 0);
    chk("reset_ack", {ua0, ua1}, 0);
    chk("reset_gen0", gc0, 0);
    chk("reset_gen1", gc1, 0);

    // Blinker
    load_board(64'h00000000_1C000000);
    pulse_step();
    wait_quiet();
    chk("blinker_b0", board0, 64'h00000008_08080000);
    chk("blinker_b1", board1, 64'h00000008_08080000);
    chk("blinker_gen", gc0, 1);

    // Block still life
    load_board(64'h00000000_00060600);
    pulse_step();
    wait_quiet();
    chk("block_b0", board0, 64'h00000000_00060600);
    chk("block_b1", board1, 64'h00000000_00060600);

    // Edge handling, flat versus toroidal
    load_board(64'h00000000_00000083);
    pulse_step();
    wait_quiet();
    chk("edge_flat", board0, 64'h0);
    chk("edge_wrap", board1, 64'h01000000_00000101);

    // Simultaneous user write and step, then a second step mid-generation
    load_board(64'h00000000_00070204);
    user_write(3'd5, 8'hA5, 1'b1);
    chk("t5_idle_after_ack", bz0, 0);
    tick();
    chk("t5_gen_started", bz0, 1);
    tick();
    tick();
    pulse_step();
    wait_quiet();
    chk("t5_gen0", gc0, 5);
    chk("t5_gen1", gc1, 1);

    // Reset in the middle of WRITE, with a step on the reset cycle
    load_board(64'h3C00_1818_0066_4200);
    pulse_step();
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (bz0 && rs0 == 3'd4) seen = 1'b1;
      else tick();
    end
    if (!seen) chk("row4_timeout", 0, 1);
    reset_n = 1'b0;
    step    = 1'b1;
    tick();
    reset_n = 1'b1;
    step    = 1'b0;
    chk("rst_busy", {bz0, bz1}, 0);
    chk("rst_load", {lr0, lr1}, 0);
    chk("rst_done", {dn0, dn1}, 0);
    chk("rst_gen", {gc0, gc1}, 0);
    tick();
    tick();
    chk("rst_no_gen", {bz0, bz1}, 0);

    // Randomised traffic
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 4))
        0: user_write(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
        1: pulse_step();
        2: repeat ($urandom_range(0, 10)) tick();
        3: begin
          pulse_step();
          repeat ($urandom_range(1, 6)) tick();
          pulse_step();
        end
        default: user_write(3'($urandom_range(0, 7)), 8'($urandom), 1'b0);
      endcase
    end
    wait_quiet();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
